imem_loader: RTL and testbench

//  Byte-stream program loader for the stack CPU: accepts a length-prefixed byte stream on a valid/ready port,

---
 rtl/imem_loader_pkg.sv | 44 ++++
 rtl/imem_loader_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the stack CPU instruction-memory loader:
//   - instruction memory geometry (depth / address width)
//   - stack CPU opcode values
//   - loader FSM state encoding
//   - small helper functions (header count validation, checksum fold)
// No ports (package).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 128;
    localparam int IMEM_ADDR_W = 7;

    // Stack CPU opcodes
    localparam logic [5:0] OP_PUSH = 6'd1;
    localparam logic [5:0] OP_POP  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;
    localparam logic [5:0] OP_SUB  = 6'd4;
    localparam logic [5:0] OP_DUP  = 6'd5;
    localparam logic [5:0] OP_SWAP = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_AND  = 6'd8;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        BYTES = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    // A header count is usable only if it is non-zero and fits in memory.
    function automatic logic count_ok(input logic [7:0] n, input int unsigned depth);
        return (n != 8'd0) && (32'(n) <= depth);
    endfunction

    // Running XOR checksum over payload bytes.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_word_packer
// Big-endian byte-to-word packer. The first three bytes of a word are held in
// a 24-bit shift register; the fourth byte is merged combinationally so the
// complete word is available in the same cycle the last byte is accepted.
// Ports:
//   i_clock       rising-edge clock
//   i_reset_n     asynchronous active-low reset
//   i_clear       synchronous clear of partial word and byte index
//   i_shift       shift i_byte in (one accepted stream byte)
//   i_byte        stream byte
//   o_word        {held bytes, i_byte} - complete word when o_word_ready
//   o_word_ready  next shifted byte completes a word (byte index == 3)
// -----------------------------------------------------------------------------
module imem_loader_word_packer (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_word;
    logic [1:0]  r_idx;

    assign o_word       = {r_word, i_byte};
    assign o_word_ready = (r_idx == 2'd3);

    // Byte shift register and byte index; the 2-bit index wraps to 0 after each word.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_word <= 24'd0;
            r_idx  <= 2'd0;
        end else if (i_clear) begin
            r_word <= 24'd0;
            r_idx  <= 2'd0;
        end else if (i_shift) begin
            r_word <= {r_word[15:0], i_byte};
            r_idx  <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Byte-stream program loader for the stack CPU. Accepts a length-prefixed byte
// stream (count byte N, then N*4 payload bytes, big-endian words), writes the
// words to instruction memory addresses 0..N-1 and holds the CPU in reset until
// the load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN - after the last word one
// extra byte is accepted and compared against the XOR of all payload bytes;
// mismatch ends in ERROR.
// Ports:
//   i_clock       rising-edge clock
//   i_reset_n     asynchronous active-low reset
//   i_start       restart pulse, honoured only in DONE / ERROR
//   i_rx_data     stream byte
//   i_rx_valid    stream byte valid
//   o_rx_ready    loader accepts a byte (transfer = valid && ready)
//   o_mem_we      instruction memory write strobe (one cycle per word)
//   o_mem_addr    write address
//   o_mem_wdata   write data
//   o_cpu_reset   active-high CPU reset, released only in DONE
//   o_load_done   load completed
//   o_load_error  bad header (or checksum) - waiting for start
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_load_done,
    output logic              o_load_error
);

    loader_state_t     r_state;
    logic [7:0]        r_count;
    logic              r_rx_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_reset;
    logic              r_load_done;
    logic              r_load_error;

    logic              w_accept;
    logic              w_shift;
    logic              w_clear;
    logic [31:0]       w_word;
    logic              w_word_ready;
    logic [7:0]        w_next_cnt;
    logic              w_last;

    assign w_accept   = i_rx_valid && r_rx_ready;
    assign w_shift    = w_accept && (r_state == BYTES);
    assign w_clear    = (r_state == HDR);
    // The address register doubles as the word counter: words written so far
    // after this write is address + 1.
    assign w_next_cnt = 8'(r_mem_addr) + 8'd1;
    assign w_last     = (w_next_cnt == r_count);

    imem_loader_word_packer u_packer (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    // Running XOR of payload bytes; restarts whenever the loader waits for a header.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_chk <= 8'd0;
        end else if (r_state == HDR) begin
            r_chk <= 8'd0;
        end else if (w_shift) begin
            r_chk <= chk_fold(r_chk, i_rx_data);
        end
    end
`endif

    // Loader FSM with all outputs registered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= HDR;
            r_count      <= 8'd0;
            r_rx_ready   <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_accept) begin
                        if (count_ok(i_rx_data, DEPTH)) begin
                            r_count    <= i_rx_data;
                            r_mem_addr <= '0;
                            r_state    <= BYTES;
                        end else begin
                            r_rx_ready   <= 1'b0;
                            r_load_error <= 1'b1;
                            r_state      <= ERROR;
                        end
                    end
                end
                BYTES: begin
                    // Strobe and data are launched here so they are visible
                    // for exactly the one cycle spent in WRITE.
                    if (w_accept && w_word_ready) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                        r_rx_ready  <= 1'b0;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        // Address stays on the final word so it can never wrap.
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_rx_ready  <= 1'b1;
                        r_state     <= CHK;
`else
                        r_cpu_reset <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= DONE;
`endif
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_rx_ready <= 1'b1;
                        r_state    <= BYTES;
                    end
                end
                CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (i_rx_data == r_chk) begin
                            r_cpu_reset <= 1'b0;
                            r_load_done <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_load_error <= 1'b1;
                            r_state      <= ERROR;
                        end
                    end
`else
                    // Unreachable without the checksum stage; fail safe.
                    r_rx_ready   <= 1'b0;
                    r_load_error <= 1'b1;
                    r_state      <= ERROR;
`endif
                end
                DONE, ERROR: begin
                    if (i_start) begin
                        r_rx_ready   <= 1'b1;
                        r_mem_addr   <= '0;
                        r_cpu_reset  <= 1'b1;
                        r_load_done  <= 1'b0;
                        r_load_error <= 1'b0;
                        r_state      <= HDR;
                    end
                end
                default: begin
                    r_rx_ready   <= 1'b0;
                    r_cpu_reset  <= 1'b1;
                    r_load_done  <= 1'b0;
                    r_load_error <= 1'b1;
                    r_state      <= ERROR;
                end
            endcase
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_load_done  = r_load_done;
    assign o_load_error = r_load_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected memory writes are derived from
// the byte stream the bench sends (big-endian packing, sequential addresses);
// a compare process checks every write strobe and the flag invariants each
// cycle. Directed literal expectations pin the model on the reference stream.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_mem_we;
    logic [6:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_cpu_reset;
    logic        o_load_done;
    logic        o_load_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    bit          armed    = 1'b0;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] mem_model [0:127];
    logic [7:0]  pay[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .i_clock      (clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_cpu_reset  (o_cpu_reset),
        .o_load_done  (o_load_done),
        .o_load_error (o_load_error)
    );

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: every write against the expected queue, plus flag invariants.
    always @(negedge clk) begin
        if (armed) begin
            if (o_mem_we === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    chk_bit("unexpected_write", 1'b1, 1'b0);
                end else begin
                    chk_word("wr_addr", 32'(o_mem_addr), exp_addr_q.pop_front());
                    chk_word("wr_data", o_mem_wdata, exp_data_q.pop_front());
                end
                chk_bit("we_while_ready", o_rx_ready, 1'b0);
                mem_model[o_mem_addr] = o_mem_wdata;
                n_writes++;
            end
            chk_bit("cpu_reset_vs_done", o_cpu_reset, ~o_load_done);
            chk_bit("done_and_error", o_load_done & o_load_error, 1'b0);
            if ((o_load_done | o_load_error) === 1'b1)
                chk_bit("ready_when_idle", o_rx_ready, 1'b0);
        end
    end

    task automatic check_reset_values();
        chk_bit ("rst_rx_ready",   o_rx_ready,   1'b1);
        chk_bit ("rst_mem_we",     o_mem_we,     1'b0);
        chk_word("rst_mem_addr",   32'(o_mem_addr), 32'd0);
        chk_word("rst_mem_wdata",  o_mem_wdata,  32'd0);
        chk_bit ("rst_cpu_reset",  o_cpu_reset,  1'b1);
        chk_bit ("rst_load_done",  o_load_done,  1'b0);
        chk_bit ("rst_load_error", o_load_error, 1'b0);
    endtask

    // Offer one byte, optionally after random idle cycles; returns once accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  budget = 200;
        bit  took   = 1'b0;
        logic rdy;
        if (clk == 1'b0) begin
            @(posedge clk); #1;
        end
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                i_rx_valid = 1'b0;
                i_rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!took && budget > 0) begin
            @(negedge clk);
            rdy = o_rx_ready;
            @(posedge clk); #1;
            if (rdy === 1'b1) took = 1'b1;
            budget--;
        end
        i_rx_valid = 1'b0;
        if (!took) chk_bit("send_timeout", 1'b0, 1'b1);
    endtask

    // Wait (bounded) for DONE or ERROR and check the final flags.
    task automatic wait_end(input bit exp_done);
        int budget = 30;
        @(negedge clk);
        while ((o_load_done | o_load_error) !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk_bit("end_done",      o_load_done,  exp_done);
        chk_bit("end_error",     o_load_error, ~exp_done);
        chk_bit("end_cpu_reset", o_cpu_reset,  ~exp_done);
        chk_bit("end_rx_ready",  o_rx_ready,   1'b0);
    endtask

    task automatic pulse_start();
        if (clk == 1'b1) @(negedge clk);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk_bit ("start_rx_ready",   o_rx_ready,   1'b1);
        chk_bit ("start_load_done",  o_load_done,  1'b0);
        chk_bit ("start_load_error", o_load_error, 1'b0);
        chk_bit ("start_cpu_reset",  o_cpu_reset,  1'b1);
        chk_word("start_mem_addr",   32'(o_mem_addr), 32'd0);
    endtask

    // Full load of payload p (N = size/4 words); expectations built from the stream.
    task automatic run_load(input logic [7:0] p[$], input bit gaps, input bit chk_good, input bit exp_done);
        int          n  = p.size() / 4;
        int          w0 = n_writes;
        logic [7:0]  x  = 8'd0;
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = {p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]};
            exp_addr_q.push_back(k);
            exp_data_q.push_back(w);
        end
        send_byte(8'(n), gaps);
        foreach (p[i]) begin
            send_byte(p[i], gaps);
            x = x ^ p[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(chk_good ? x : (x ^ 8'h01), gaps);
`else
        if (!chk_good) x = 8'd0;
`endif
        wait_end(exp_done);
        chk_word("write_count", 32'(n_writes - w0), 32'(n));
        chk_word("pending_writes", 32'(exp_data_q.size()), 32'd0);
        for (int k = 0; k < n; k++) begin
            w = {p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]};
            chk_word("mem_image", mem_model[k], w);
        end
    endtask

    task automatic rand_payload(input int n);
        pay.delete();
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 32'd0;
        i_reset_n  = 1'b0;
        i_start    = 1'b0;
        i_rx_data  = 8'd0;
        i_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        armed = 1'b1;
        check_reset_values();
        @(posedge clk); #1;
        i_reset_n = 1'b1;

        // Reference stream: 02 | 04 00 00 05 | 0C 00 00 00
        pay = '{8'h04, 8'h00, 8'h00, 8'h05, 8'h0C, 8'h00, 8'h00, 8'h00};
        run_load(pay, 1'b0, 1'b1, 1'b1);
        chk_word("ref_word0", mem_model[0], 32'h0400_0005);
        chk_word("ref_word1", mem_model[1], 32'h0C00_0000);
        chk_word("ref_last_addr", 32'(o_mem_addr), 32'd1);
        pulse_start();
        pulse_start();

        // Count 0 -> ERROR; bytes offered in ERROR stay pending; start clears.
        send_byte(8'h00, 1'b0);
        wait_end(1'b0);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h02;
        repeat (3) @(negedge clk);
        chk_bit("error_holds", o_load_error, 1'b1);
        i_rx_valid = 1'b0;
        pulse_start();

        // Count 129 -> ERROR.
        send_byte(8'h81, 1'b1);
        wait_end(1'b0);
        pulse_start();

        // Count 128 -> fills memory exactly, last address 7F.
        rand_payload(128);
        run_load(pay, 1'b0, 1'b1, 1'b1);
        chk_word("full_last_addr", 32'(o_mem_addr), 32'h7F);
        pulse_start();

        // Random loads with random rx_valid gaps.
        for (int t = 0; t < 5; t++) begin
            rand_payload((t == 0) ? 3 : $urandom_range(1, 8));
            run_load(pay, 1'b1, 1'b1, 1'b1);
            pulse_start();
        end

        // Reset mid-load after 6 bytes of a 2-word load.
        rand_payload(2);
        exp_addr_q.push_back(0);
        exp_data_q.push_back({pay[0], pay[1], pay[2], pay[3]});
        send_byte(8'd2, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
        i_reset_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        chk_word("abort_pending", 32'(exp_data_q.size()), 32'd0);
        chk_word("abort_word0", mem_model[0], {pay[0], pay[1], pay[2], pay[3]});
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        rand_payload(2);
        run_load(pay, 1'b1, 1'b1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        pay = '{8'h04, 8'h00, 8'h00, 8'h05};
        run_load(pay, 1'b0, 1'b1, 1'b1);
        pulse_start();
        run_load(pay, 1'b0, 1'b0, 1'b0);
        chk_bit("chk_bad_cpu_reset", o_cpu_reset, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
